// File: rtl/fp_pkg.sv
// Shared types and constants for the sequential binary32 adder.
// Also provides operand classification.
package fp_pkg;
   localparam int MANT_W    = 24;
   localparam int ALIGN_CAP = 26;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC00000;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] frac;
   } fp32_t;

   typedef struct packed {
      logic is_inf;
      logic is_nan;
      logic is_zero;
   } fp_class_t;

   typedef enum logic [2:0] {
      IDLE, SPECIAL, ALIGN, ADD, NORM, DONE
   } seq_state_t;

   function automatic fp_class_t fp_classify(input fp32_t v);
      fp_class_t c;
      c.is_inf  = (v.exp == EXP_MAX) && (v.frac == '0);
      c.is_nan  = (v.exp == EXP_MAX) && (v.frac != '0);
      c.is_zero = (v.exp == '0);
      return c;
   endfunction
endpackage

// File: rtl/fp_unpack.sv
// Combinational split of an operand pair into sign/exponent/mantissa plus classification.
// Also computes the alignment distance. Subnormals are treated as zero.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [31:0]       x_i,
   input  logic [31:0]       y_i,
   output logic              x_sign_o,
   output logic              y_sign_o,
   output logic [7:0]        x_exp_o,
   output logic [7:0]        y_exp_o,
   output logic [MANT_W-1:0] x_mant_o,
   output logic [MANT_W-1:0] y_mant_o,
   output logic              x_inf_o,
   output logic              y_inf_o,
   output logic              any_nan_o,
   output logic              any_special_o,
   output logic              x_greater_o,
   output logic [7:0]        exp_shift_o
);
   fp32_t     x, y;
   fp_class_t xc, yc;

   assign x  = fp32_t'(x_i);
   assign y  = fp32_t'(y_i);
   assign xc = fp_classify(x);
   assign yc = fp_classify(y);

   assign x_sign_o = x.sign;
   assign y_sign_o = y.sign;
   assign x_exp_o  = x.exp;
   assign y_exp_o  = y.exp;
   assign x_mant_o = xc.is_zero ? '0 : {1'b1, x.frac};
   assign y_mant_o = yc.is_zero ? '0 : {1'b1, y.frac};

   assign x_inf_o       = xc.is_inf;
   assign y_inf_o       = yc.is_inf;
   assign any_nan_o     = xc.is_nan | yc.is_nan;
   assign any_special_o = xc.is_nan | yc.is_nan | xc.is_inf | yc.is_inf;

   // X wins exponent ties
   assign x_greater_o = (x.exp >= y.exp);
   assign exp_shift_o = x_greater_o ? (x.exp - y.exp) : (y.exp - x.exp);
endmodule

// File: rtl/fp_add_seq.sv
// Multi-cycle binary32 adder: bit-serial alignment and normalization on one shift register.
// Define FPU_SUB_EN to add op_sub_i, which negates Y so the block computes X-Y.
//
// state   | meaning
// IDLE    | waiting for an operand pair
// SPECIAL | NaN/infinity result selection
// ALIGN   | smaller mantissa >>1 per cycle
// ADD     | signed mantissa add/subtract
// NORM    | one normalization shift per cycle
// DONE    | result held until accepted
module fp_add_seq
   import fp_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] x_i,
   input  logic [31:0] y_i,
   input  logic        in_valid_i,
`ifdef FPU_SUB_EN
   input  logic        op_sub_i,
`endif
   output logic        in_ready_o,
   output logic [31:0] result_o,
   output logic        result_valid_o,
   input  logic        result_ready_i,
   output logic        invalid_o,
   output logic        overflow_o,
   output logic        underflow_o,
   output logic        busy_o
);
   localparam logic [7:0] CAP8 = 8'(ALIGN_CAP);

   seq_state_t        state_q;
   logic [31:0]       x_q, y_q, x_d, y_d, y_in;
   logic [MANT_W-1:0] ma_q;
   logic [MANT_W:0]   sh_q, sum_c, sh_n;
   logic [7:0]        exp_q, cnt_q, exp_n, cnt_init;
   logic              sa_q, sb_q, sign_c;
   logic [31:0]       result_q;
   logic              valid_q, inv_q, ovf_q, unf_q;
   logic              accept;

   logic              x_sign, y_sign, x_inf, y_inf, any_nan, any_special, x_gt;
   logic [7:0]        x_exp, y_exp, exp_shift;
   logic [MANT_W-1:0] x_mant, y_mant;

   assign accept = in_valid_i && (state_q == IDLE);

   // Unpack sees the incoming pair on accept and the held pair afterwards
   always_comb begin
      y_in = y_i;
`ifdef FPU_SUB_EN
      y_in[31] = y_i[31] ^ op_sub_i;
`endif
      x_d = x_q;
      y_d = y_q;
      if (accept) begin
         x_d = x_i;
         y_d = y_in;
      end
   end

   fp_unpack u_unpack (
      .x_i           (x_d),
      .y_i           (y_d),
      .x_sign_o      (x_sign),
      .y_sign_o      (y_sign),
      .x_exp_o       (x_exp),
      .y_exp_o       (y_exp),
      .x_mant_o      (x_mant),
      .y_mant_o      (y_mant),
      .x_inf_o       (x_inf),
      .y_inf_o       (y_inf),
      .any_nan_o     (any_nan),
      .any_special_o (any_special),
      .x_greater_o   (x_gt),
      .exp_shift_o   (exp_shift)
   );

   assign cnt_init = (exp_shift >= CAP8) ? CAP8 : exp_shift;

   always_comb begin
      sum_c  = '0;
      sign_c = sa_q;
      if (sa_q == sb_q) begin
         sum_c = {1'b0, ma_q} + sh_q;
      end else if ({1'b0, ma_q} >= sh_q) begin
         sum_c = {1'b0, ma_q} - sh_q;
      end else begin
         sum_c  = sh_q - {1'b0, ma_q};
         sign_c = sb_q;
      end
   end

   assign sh_n  = sh_q[MANT_W] ? (sh_q >> 1) : (sh_q << 1);
   assign exp_n = sh_q[MANT_W] ? (exp_q + 8'd1) : (exp_q - 8'd1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         x_q      <= '0;
         y_q      <= '0;
         ma_q     <= '0;
         sh_q     <= '0;
         exp_q    <= '0;
         cnt_q    <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
         inv_q    <= 1'b0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               x_q <= x_d;
               y_q <= y_d;
               if (any_special) begin
                  state_q <= SPECIAL;
               end else begin
                  ma_q  <= x_gt ? x_mant : y_mant;
                  sh_q  <= {1'b0, (x_gt ? y_mant : x_mant)};
                  exp_q <= x_gt ? x_exp : y_exp;
                  sa_q  <= x_gt ? x_sign : y_sign;
                  sb_q  <= x_gt ? y_sign : x_sign;
                  cnt_q <= cnt_init;
                  state_q <= (cnt_init == 8'd0) ? ADD : ALIGN;
               end
            end
            SPECIAL: begin
               if (any_nan || (x_inf && y_inf && (x_sign != y_sign))) begin
                  result_q <= QNAN;
                  inv_q    <= 1'b1;
               end else begin
                  result_q <= x_inf ? x_q : y_q;
               end
               valid_q <= 1'b1;
               state_q <= DONE;
            end
            ALIGN: begin
               sh_q  <= sh_q >> 1;
               cnt_q <= cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_q <= ADD;
            end
            ADD: begin
               sh_q <= sum_c;
               sa_q <= sign_c;
               if (sum_c == '0) begin
                  result_q <= '0;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else if (sum_c[MANT_W] || !sum_c[MANT_W-1]) begin
                  state_q <= NORM;
               end else begin
                  result_q <= {sign_c, exp_q, sum_c[22:0]};
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end
            end
            NORM: begin
               sh_q  <= sh_n;
               exp_q <= exp_n;
               if (exp_n == EXP_MAX) begin
                  result_q <= {sa_q, EXP_MAX, 23'd0};
                  ovf_q    <= 1'b1;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else if (exp_n == 8'd0) begin
                  result_q <= {sa_q, 31'd0};
                  unf_q    <= 1'b1;
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end else if (sh_n[MANT_W-1]) begin
                  result_q <= {sa_q, exp_n, sh_n[22:0]};
                  valid_q  <= 1'b1;
                  state_q  <= DONE;
               end
            end
            DONE: if (result_ready_i) begin
               valid_q <= 1'b0;
               inv_q   <= 1'b0;
               ovf_q   <= 1'b0;
               unf_q   <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready_o     = (state_q == IDLE);
   assign busy_o         = (state_q != IDLE);
   assign result_o       = result_q;
   assign result_valid_o = valid_q;
   assign invalid_o      = inv_q;
   assign overflow_o     = ovf_q;
   assign underflow_o    = unf_q;
endmodule

// File: tb/tb_fp_add_seq.sv
// Directed bench for fp_add_seq: an integer-arithmetic model of truncating binary32 addition
// checked every valid cycle, plus literal expectations per vector.
module tb_fp_add_seq;
   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] x_i = '0, y_i = '0;
   logic        in_valid_i = 1'b0;
   logic        op_sub_i = 1'b0;
   logic        in_ready_o, result_valid_o, invalid_o, overflow_o, underflow_o, busy_o;
   logic        result_ready_i = 1'b0;
   logic [31:0] result_o;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc   = 0;
   bit pending = 1'b0;
   bit seen    = 1'b0;
   logic [31:0] last_r;

   typedef struct {
      logic [31:0] r;
      logic [2:0]  fl;
      int          lat;
   } exp_t;
   exp_t cur;

   fp_add_seq dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .x_i            (x_i),
      .y_i            (y_i),
      .in_valid_i     (in_valid_i),
`ifdef FPU_SUB_EN
      .op_sub_i       (op_sub_i),
`endif
      .in_ready_o     (in_ready_o),
      .result_o       (result_o),
      .result_valid_o (result_valid_o),
      .result_ready_i (result_ready_i),
      .invalid_o      (invalid_o),
      .overflow_o     (overflow_o),
      .underflow_o    (underflow_o),
      .busy_o         (busy_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, want);
      end
   endtask

   // Align by discarding shifted-out bits, add exactly, then normalize with truncation
   function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
      exp_t   e;
      int     ex, ey, ea, d, cnt, n;
      longint mx, my, ma, mb, s, m;
      bit     sa, sb, neg, xinf, yinf, xnan, ynan;
      e.r = '0; e.fl = 3'b000; e.lat = 0;
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      xinf = (ex == 255) && (x[22:0] == 23'd0);
      yinf = (ey == 255) && (y[22:0] == 23'd0);
      xnan = (ex == 255) && (x[22:0] != 23'd0);
      ynan = (ey == 255) && (y[22:0] != 23'd0);
      if (xnan || ynan || xinf || yinf) begin
         e.lat = 2;
         if (xnan || ynan || (xinf && yinf && (x[31] != y[31]))) begin
            e.r  = 32'h7FC00000;
            e.fl = 3'b100;
         end else begin
            e.r = xinf ? x : y;
         end
         return e;
      end
      mx = (ex == 0) ? 64'd0 : (64'd8388608 + longint'(x[22:0]));
      my = (ey == 0) ? 64'd0 : (64'd8388608 + longint'(y[22:0]));
      if (ex >= ey) begin
         ma = mx; sa = x[31]; mb = my; sb = y[31]; ea = ex; d = ex - ey;
      end else begin
         ma = my; sa = y[31]; mb = mx; sb = x[31]; ea = ey; d = ey - ex;
      end
      cnt = (d > 26) ? 26 : d;
      mb  = mb >> cnt;
      s   = (sa ? -ma : ma) + (sb ? -mb : mb);
      if (s == 0) begin
         e.lat = 2 + cnt;
         return e;
      end
      neg = (s < 0);
      m   = neg ? -s : s;
      n   = 0;
      if (m >= 64'd16777216) begin
         m = m >> 1; ea++; n = 1;
      end else begin
         while (m < 64'd8388608) begin
            m = m << 1; ea--; n++;
            if (ea == 0) break;
         end
      end
      e.lat = 2 + cnt + n;
      if (ea >= 255) begin
         e.r = {neg, 8'hFF, 23'd0}; e.fl = 3'b010;
      end else if (ea <= 0) begin
         e.r = {neg, 31'd0}; e.fl = 3'b001;
      end else begin
         e.r = {neg, ea[7:0], m[22:0]};
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (!rst_i && result_valid_o) begin
         if (!pending) begin
            chk("unexpected_valid", {31'd0, result_valid_o}, 32'd0);
         end else begin
            if (!seen) begin
               seen = 1'b1;
               chk("latency", 32'(cyc - acc), 32'(cur.lat));
            end
            chk("result", result_o, cur.r);
            chk("flags", {29'd0, invalid_o, overflow_o, underflow_o}, {29'd0, cur.fl});
            chk("in_ready_while_done", {31'd0, in_ready_o}, 32'd0);
         end
      end
   end

   task automatic start_op(input logic [31:0] x, input logic [31:0] y);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready_o) chk("ready_timeout", 32'd0, 32'd1);
      x_i = x; y_i = y; in_valid_i = 1'b1;
      cur = model(x, y);
      acc = cyc; seen = 1'b0; pending = 1'b1;
      @(posedge clk);
      #1 in_valid_i = 1'b0;
   endtask

   task automatic finish_op(input int hold);
      int w;
      w = 0;
      @(negedge clk);
      while (!result_valid_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!result_valid_o) chk("valid_timeout", 32'd0, 32'd1);
      repeat (hold) @(negedge clk);
      last_r = result_o;
      result_ready_i = 1'b1;
      @(posedge clk);
      #1 result_ready_i = 1'b0;
      pending = 1'b0;
      @(negedge clk);
      chk("idle_after_handshake", {30'd0, in_ready_o, result_valid_o}, 32'd2);
   endtask

   task automatic do_vec(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] r, input logic [2:0] fl, input int lat, input int hold);
      exp_t m;
      m = model(x, y);
      chk({name, "_model_r"}, m.r, r);
      chk({name, "_model_fl"}, {29'd0, m.fl}, {29'd0, fl});
      chk({name, "_model_lat"}, 32'(m.lat), 32'(lat));
      start_op(x, y);
      finish_op(hold);
      chk({name, "_dut_r"}, last_r, r);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("rst_result", result_o, 32'd0);
      chk("rst_status", {26'd0, result_valid_o, invalid_o, overflow_o, underflow_o, busy_o, in_ready_o},
          32'd1);

      do_vec("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000, 3, 0);
      do_vec("cap_shift",    32'h3F800000, 32'h30800000, 32'h3F800000, 3'b000, 28, 0);
      do_vec("exact_zero",   32'h3FC00000, 32'hBFC00000, 32'h00000000, 3'b000, 2, 0);
      do_vec("nan_in",       32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100, 2, 0);
      do_vec("inf_minus",    32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100, 2, 0);
      do_vec("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b010, 3, 5);
      do_vec("underflow",    32'h01000000, 32'h80C00000, 32'h00000000, 3'b001, 5, 0);
      do_vec("cancel_half",  32'h3F800000, 32'hBF000000, 32'h3F000000, 3'b000, 4, 0);
      do_vec("inf_plus_one", 32'h3F800000, 32'hFF800000, 32'hFF800000, 3'b000, 2, 1);
      do_vec("truncate",     32'h3F800000, 32'h3F800001, 32'h40000000, 3'b000, 3, 0);
      do_vec("y_larger",     32'h3F800000, 32'h40400000, 32'h40800000, 3'b000, 4, 0);
      do_vec("zero_plus",    32'h00000000, 32'hC0A00000, 32'hC0A00000, 3'b000, 28, 2);

      // Abort an operation partway through alignment
      start_op(32'h3F800000, 32'h30800000);
      repeat (5) @(negedge clk);
      chk("busy_mid_align", {31'd0, busy_o}, 32'd1);
      rst_i = 1'b1;
      pending = 1'b0;
      @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      chk("abort_status", {29'd0, result_valid_o, busy_o, in_ready_o}, 32'd1);
      repeat (30) @(negedge clk);
      chk("abort_no_result", {31'd0, result_valid_o}, 32'd0);
      do_vec("after_abort",  32'h40000000, 32'h40000000, 32'h40800000, 3'b000, 3, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
